// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - fetch-PC controller: next-PC select, stall hold, delay-slot BD tracking, fetch-address check
//
// Owns the F-stage PC register and picks the next fetch address.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   stall             F/D hazard stall; PC and F_bd hold
//   req               CP0 exception/interrupt request (beats everything)
//   EPC, D_eret       eret return address and D-stage eret flag
//   D_pc, D_PCSel     D-stage PC and next-PC source select
//   D_branch          branch condition true
//   D_imm, D_offset   jump index and branch offset
//   D_ra              forwarded rs for jr/jalr
//   F_pc              current fetch address
//   F_bd              F-stage instruction sits in a delay slot
//   F_adel            F_pc misaligned or outside instruction memory
//   flush_F           F/D register loads a nop this cycle
module npc_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [31:0] EPC,
    input  logic        D_eret,
    input  logic [31:0] D_pc,
    input  logic [2:0]  D_PCSel,
    input  logic        D_branch,
    input  logic [25:0] D_imm,
    input  logic [15:0] D_offset,
    input  logic [31:0] D_ra,
    output logic [31:0] F_pc,
    output logic        F_bd,
    output logic        F_adel,
    output logic        flush_F
);

    localparam logic [2:0] SEL_BR = 3'd1;
    localparam logic [2:0] SEL_J  = 3'd2;
    localparam logic [2:0] SEL_JR = 3'd3;

    logic [31:0] r_pc;
    logic        r_bd;

    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_redir_tgt;
    logic        w_redirect;
    logic        w_ctrl_xfer;
    logic [31:0] w_next_pc;

    assign w_br_tgt = D_pc + 32'd4 + {{14{D_offset[15]}}, D_offset, 2'b00};
    assign w_j_tgt  = {D_pc[31:28], D_imm, 2'b00};

    // Any control-transfer instruction, taken or not; its successor is a delay slot.
    assign w_ctrl_xfer = (D_PCSel == SEL_BR) || (D_PCSel == SEL_J) || (D_PCSel == SEL_JR);

    always_comb begin
        w_redirect  = 1'b0;
        w_redir_tgt = w_br_tgt;
        case (D_PCSel)
            SEL_BR: begin
                w_redirect  = D_branch;
                w_redir_tgt = w_br_tgt;
            end
            SEL_J: begin
                w_redirect  = 1'b1;
                w_redir_tgt = w_j_tgt;
            end
            SEL_JR: begin
                w_redirect  = 1'b1;
                w_redir_tgt = D_ra;
            end
            default: begin
                w_redirect  = 1'b0;
                w_redir_tgt = w_br_tgt;
            end
        endcase
    end

    // Exception entry overrides stall; stall in turn masks eret and redirects.
    always_comb begin
        if (req)
            w_next_pc = EXC_ENTRY;
        else if (stall)
            w_next_pc = r_pc;
        else if (D_eret)
            w_next_pc = EPC;
        else if (w_redirect)
            w_next_pc = w_redir_tgt;
        else
            w_next_pc = r_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
            r_bd <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            // eret clears BD even under stall, matching req.
            if (req || D_eret)
                r_bd <= 1'b0;
            else if (!stall)
                r_bd <= DELAY_SLOT && w_ctrl_xfer;
        end
    end

    assign F_pc    = r_pc;
    assign F_bd    = r_bd;
    assign F_adel  = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);
    assign flush_F = req || (D_eret && !stall) || (!DELAY_SLOT && w_redirect && !stall);

endmodule

// File: tb/tb_npc_ctrl.sv
// tb/tb_npc_ctrl.sv - self-checking bench for npc_ctrl, delay-slot and no-delay-slot instances
module tb_npc_ctrl;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic [31:0] EPC = '0;
    logic        D_eret = 1'b0;
    logic [31:0] D_pc = '0;
    logic [2:0]  D_PCSel = '0;
    logic        D_branch = 1'b0;
    logic [25:0] D_imm = '0;
    logic [15:0] D_offset = '0;
    logic [31:0] D_ra = '0;

    logic [31:0] pc_ds0, pc_ds1;
    logic        bd_ds0, bd_ds1, adel_ds0, adel_ds1, fl_ds0, fl_ds1;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    npc_ctrl #(.DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .EPC(EPC), .D_eret(D_eret),
        .D_pc(D_pc), .D_PCSel(D_PCSel), .D_branch(D_branch), .D_imm(D_imm),
        .D_offset(D_offset), .D_ra(D_ra), .F_pc(pc_ds0), .F_bd(bd_ds0),
        .F_adel(adel_ds0), .flush_F(fl_ds0)
    );

    npc_ctrl #(.DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .EPC(EPC), .D_eret(D_eret),
        .D_pc(D_pc), .D_PCSel(D_PCSel), .D_branch(D_branch), .D_imm(D_imm),
        .D_offset(D_offset), .D_ra(D_ra), .F_pc(pc_ds1), .F_bd(bd_ds1),
        .F_adel(adel_ds1), .flush_F(fl_ds1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: architectural PC and BD per delay-slot configuration.
    logic [31:0] m_pc [2];
    logic        m_bd [2];

    function automatic logic [31:0] target_of(input logic [2:0] sel);
        logic [31:0] off;
        off = 32'($signed(D_offset)) * 4;
        case (sel)
            3'd1:    return D_pc + 4 + off;
            3'd2:    return {D_pc[31:28], D_imm, 2'b00};
            3'd3:    return D_ra;
            default: return D_pc + 4;
        endcase
    endfunction

    always @(negedge clk) begin
        logic        redir, xfer, bad;
        logic [31:0] apc [2];
        logic        abd [2], aad [2], afl [2];
        apc[0] = pc_ds0; abd[0] = bd_ds0; aad[0] = adel_ds0; afl[0] = fl_ds0;
        apc[1] = pc_ds1; abd[1] = bd_ds1; aad[1] = adel_ds1; afl[1] = fl_ds1;
        if (!reset) begin
            m_pc[0] = PC_RESET; m_pc[1] = PC_RESET;
            m_bd[0] = 1'b0;     m_bd[1] = 1'b0;
        end
        xfer  = (D_PCSel >= 3'd1) && (D_PCSel <= 3'd3);
        redir = (D_PCSel == 3'd1 && D_branch) || D_PCSel == 3'd2 || D_PCSel == 3'd3;
        for (int d = 0; d < 2; d++) begin
            bad = (m_pc[d] % 4 != 0) || (m_pc[d] < IM_LO) || (m_pc[d] > IM_HI);
            chk($sformatf("model F_pc ds%0d", d), apc[d], m_pc[d]);
            chk($sformatf("model F_bd ds%0d", d), 32'(abd[d]), 32'(m_bd[d]));
            chk($sformatf("model F_adel ds%0d", d), 32'(aad[d]), 32'(bad));
            chk($sformatf("model flush_F ds%0d", d), 32'(afl[d]),
                32'(req || (D_eret && !stall) || (d == 0 && redir && !stall)));
        end
        // State the next rising edge will produce (inputs are stable until then).
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_pc[d] = PC_RESET; m_bd[d] = 1'b0;
            end else begin
                if (req)         m_pc[d] = EXC_ENTRY;
                else if (stall)  m_pc[d] = m_pc[d];
                else if (D_eret) m_pc[d] = EPC;
                else if (redir)  m_pc[d] = target_of(D_PCSel);
                else             m_pc[d] = m_pc[d] + 4;
                if (req || D_eret)  m_bd[d] = 1'b0;
                else if (!stall)    m_bd[d] = (d == 1) && xfer;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        stall = 0; req = 0; D_eret = 0; D_PCSel = 0; D_branch = 0;
    endtask

    function automatic logic [31:0] legal_addr;
        return IM_LO + 4 * $urandom_range(0, (IM_HI - IM_LO) / 4);
    endfunction

    initial begin
        // Reset state and free-running fetch.
        @(negedge clk);
        chk("reset F_pc", pc_ds1, 32'h3000);
        chk("reset F_bd", 32'(bd_ds1), 0);
        chk("reset F_adel", 32'(adel_ds1), 0);
        chk("reset flush_F", 32'(fl_ds1), 0);
        tick; reset = 1;
        @(negedge clk); chk("run0 F_pc", pc_ds1, 32'h3000);
        tick; @(negedge clk); chk("run1 F_pc", pc_ds1, 32'h3004);
        tick; @(negedge clk); chk("run2 F_pc", pc_ds1, 32'h3008);

        // Taken branch.
        tick; D_pc = 32'h3004; D_offset = 16'h0003; D_PCSel = 1; D_branch = 1;
        @(negedge clk);
        chk("br flush ds1", 32'(fl_ds1), 0);
        chk("br flush ds0", 32'(fl_ds0), 1);
        tick; idle;
        @(negedge clk);
        chk("br F_pc ds1", pc_ds1, 32'h3014);
        chk("br F_bd ds1", 32'(bd_ds1), 1);
        chk("br F_bd ds0", 32'(bd_ds0), 0);

        // jr, no delay slot.
        tick; D_PCSel = 3; D_ra = 32'h3100;
        @(negedge clk); chk("jr flush ds0", 32'(fl_ds0), 1);
        tick; idle;
        @(negedge clk);
        chk("jr F_pc ds0", pc_ds0, 32'h3100);
        chk("jr F_bd ds0", 32'(bd_ds0), 0);

        // Stalled j.
        tick; stall = 1; D_PCSel = 2; D_pc = 32'h3000; D_imm = 26'h0000C40;
        @(negedge clk); chk("stall0 F_pc", pc_ds1, 32'h3104);
        tick; @(negedge clk); chk("stall1 F_pc", pc_ds1, 32'h3104);
        tick; stall = 0;
        tick; idle;
        @(negedge clk); chk("j F_pc", pc_ds1, 32'h3100);

        // Exception over stall + redirect, then eret.
        tick; req = 1; stall = 1; D_PCSel = 3; D_ra = 32'h5000;
        @(negedge clk); chk("req flush", 32'(fl_ds1), 1);
        tick; idle;
        @(negedge clk);
        chk("req F_pc", pc_ds1, 32'h4180);
        chk("req F_bd", 32'(bd_ds1), 0);
        tick; D_eret = 1; EPC = 32'h3008;
        @(negedge clk); chk("eret flush", 32'(fl_ds1), 1);
        tick; idle;
        @(negedge clk); chk("eret F_pc", pc_ds1, 32'h3008);

        // Fetch-address checks.
        tick; D_PCSel = 3; D_ra = 32'h3002;
        tick; idle; @(negedge clk); chk("adel 3002", 32'(adel_ds1), 1);
        tick; D_PCSel = 3; D_ra = 32'h7000;
        tick; idle; @(negedge clk); chk("adel 7000", 32'(adel_ds1), 1);
        tick; D_PCSel = 3; D_ra = 32'h6FFC;
        tick; idle; @(negedge clk); chk("adel 6FFC", 32'(adel_ds1), 0);
        tick; D_PCSel = 3; D_ra = 32'hFFFF_FFFC;
        tick; idle;
        tick; @(negedge clk);
        chk("wrap F_pc", pc_ds1, 32'h0);
        chk("wrap F_adel", 32'(adel_ds1), 1);

        // Asynchronous reset mid-stall.
        tick; stall = 1;
        @(posedge clk); #3 reset = 0; #1;
        chk("async rst F_pc", pc_ds1, 32'h3000);
        chk("async rst F_bd", 32'(bd_ds1), 0);
        tick; idle; reset = 1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            tick;
            req      = ($urandom_range(0, 15) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            D_eret   = ($urandom_range(0, 15) == 0);
            D_PCSel  = 3'($urandom_range(0, 7));
            D_branch = 1'($urandom);
            D_pc     = legal_addr();
            D_offset = 16'($urandom);
            D_imm    = 26'($urandom);
            D_ra     = ($urandom_range(0, 7) == 0) ? $urandom : legal_addr();
            EPC      = ($urandom_range(0, 7) == 0) ? $urandom : legal_addr();
            reset    = ($urandom_range(0, 199) != 0);
        end
        tick; idle; reset = 1;
        tick;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
